// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment scanner with frame-aligned (tear-free) value updates.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits above digit 0.
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 250,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [1:0]          rst_sync;
  logic                rst_int_n;
  logic [PW-1:0]       prescaler;
  logic [IW-1:0]       index;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] display;
  logic                pending;
  logic                slot_end;
  logic                frame_end;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   lz_mask;
  logic                blank_digit;
  logic [6:0]          seg_hi;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  // Assert asynchronously, release two clocks later so no flop sees a runt release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign slot_end  = (prescaler == PW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (index == IW'(DIGITS - 1));

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      prescaler <= '0;
      index     <= '0;
      shadow    <= '0;
      display   <= '0;
      pending   <= 1'b0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + 1'b1;
      if (slot_end) index <= frame_end ? '0 : index + 1'b1;
      if (load) shadow <= value;
      // A load landing on the boundary bypasses the shadow so it is not lost.
      if (frame_end && load) begin
        display <= value;
        pending <= 1'b0;
      end else if (frame_end && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nib         = 4'h0;
    onehot      = '0;
    blank_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (index == IW'(k)) begin
        nib         = display[4*k +: 4];
        onehot[k]   = 1'b1;
        blank_digit = lz_mask[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k>0 blanks when it and every more-significant nibble are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (display[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign seg_hi = decode(nib);

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      segments   <= SEG_OFF;
      digit_en   <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      if ((prescaler < PW'(BLANK_CYCLES)) || blank_digit) segments <= SEG_OFF;
      else segments <= (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
      digit_en   <= (ACTIVE_LOW != 0) ? ~onehot : onehot;
      frame_done <= frame_end;
    end
  end

endmodule
